axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI-lite initiator that turns simple command requests (write or read, address, data) into the five AXI-lite channels. It is the PS-side counterpart of `axi_slave`: it drives write-address, write-data and read-address, and accepts write-response and read-data/response. A per-transaction timeout guarantees the command interface never hangs on an unresponsive slave. Used by firmware-side sequencers and by the slave bench in place of the separate `axi_transmit`/`axi_receive` drivers.

## Interface
- `A_DATA_WIDTH`, 32, address width.
- `WD_DATA_WIDTH`, 32, data width.
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent in any non-IDLE, non-DONE state; minimum 4.

- `clk`  in  1  clock; all logic rises on posedge.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset); deassertion is synchronous to `clk` upstream.
- `cmd_valid`, `cmd_ready`  in/out  1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  A_DATA_WIDTH  byte address.
- `cmd_wdata`  in  WD_DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`, `rsp_ready`  out/in  1  result handshake.
- `rsp_rdata`  out  WD_DATA_WIDTH  read data; 0 for writes.
- `rsp_resp`  out  2  AXI response code (`OKAY`=00, SLVERR=10, DECERR=11).
- `rsp_timeout`  out  1  the transaction timed out.
- `waddr_packet`, `waddr_valid`, `waddr_ready`  out/out/in  A_DATA_WIDTH/1/1  AW channel.
- `wdata_packet`, `wdata_valid`, `wdata_ready`  out/out/in  WD_DATA_WIDTH/1/1  W channel.
- `wresp_packet`, `wresp_valid`, `wresp_ready`  in/in/out  2/1/1  B channel.
- `raddr_packet`, `raddr_valid`, `raddr_ready`  out/out/in  A_DATA_WIDTH/1/1  AR channel.
- `rdata_packet`, `rdata_valid`, `rdata_ready`  in/in/out  WD_DATA_WIDTH/1/1  R data.
- `rresp_packet`  in  2  read response, sampled together with the R handshake.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch addr/data/dir, reset the timeout counter, and go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: `waddr_valid` and `wdata_valid` are asserted together. Each is held, with a stable packet, until its own handshake. The channels complete independently, in either order or in the same cycle. A per-channel done flag prevents re-issue. When both are done, go to WR_RESP.
- WR_RESP: `wresp_ready`=1. On `wresp_valid`, latch `wresp_packet` into `rsp_resp`, set `rsp_rdata`=0 and go to DONE.
- RD_REQ: `raddr_valid` is held until `raddr_ready`, then go to RD_DATA.
- RD_DATA: `rdata_ready`=1. On `rdata_valid`, latch `rdata_packet` and `rresp_packet`, then go to DONE.
- DONE: `rsp_valid`=1 and the outputs are stable. On `rsp_ready`, go to IDLE.
- Timeout: the counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA. When it reaches `TIMEOUT_CYCLES`-1 without completing:
  - all channel valids/readies drop the next cycle;
  - `rsp_timeout`=1, `rsp_resp`=10, `rsp_rdata`=0;
  - the state goes to DONE.
- A late B/R beat arriving after a timeout is not accepted (ready stays 0).
- A handshake that completes on the expiry cycle takes priority over the timeout.
- Reset values: every valid/ready output is 0, except `cmd_ready`, which is 0 while reset is asserted and 1 in IDLE afterwards. All packets, `rsp_*` and `rsp_timeout` are 0. State is IDLE.
- Reset mid-transaction aborts immediately and emits no response.

## Timing
- All outputs are registered. There is no combinational path from any `*_ready`/`*_valid` input to any output.
- Cycle numbering: 0 = `cmd_valid`&&`cmd_ready` edge. AW/W (or AR) valid is high from cycle 1.
- Minimum write, with the slave always ready and B returned one cycle after W:
  - AW/W handshake at cycle 1;
  - `wresp_ready` high at cycle 2;
  - B handshake at cycle 2 or later;
  - `rsp_valid` asserted the cycle after the B handshake (earliest cycle 3).
- Minimum read: AR handshake at cycle 1, R handshake at cycle ≥2, `rsp_valid` the next cycle.
- Back-to-back: the cycle after the `rsp_valid`&&`rsp_ready` handshake, `cmd_ready`=1. Minimum 1 idle cycle between transactions.
- Timeout: `rsp_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after the command handshake if no handshake ever occurs.

## Test plan
- Write 0x0000_0040 ← 0xDEAD_BEEF with a slave that is always ready and B=00 → AW/W valid at cycle 1, `rsp_valid` at cycle 3, `rsp_resp`=00, `rsp_timeout`=0.
- Write with AW ready delayed 7 cycles and W ready immediate → `wdata_valid` drops after 1 beat, `waddr_valid` is held 8 cycles with a stable packet, exactly one beat per channel.
- Read 0x0000_0004 returning 0x1234_5678 with rresp=00, with `rdata_valid` delayed 5 cycles → `rsp_rdata`=0x1234_5678, `rsp_resp`=00. Then read an address past the ceiling with the slave returning -2 (0xFFFF_FFFE) → `rsp_rdata`=0xFFFF_FFFE.
- Slave never asserts `wresp_valid`, `TIMEOUT_CYCLES`=16 → `rsp_valid` at cycle 17 with `rsp_timeout`=1 and `rsp_resp`=10. A subsequent normal read succeeds.
- Hold `rsp_ready`=0 for 10 cycles in DONE → outputs stay stable and `cmd_ready`=0. Randomly oscillate every ready input for 200 mixed commands → each transaction matches the scoreboard.
- Assert `rst`=0 while in WR_RESP → all outputs go to 0 asynchronously, no `rsp_valid` is emitted, and the module is in IDLE after release.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: one command in, five AXI-lite channels out,
// one response back. A per-transaction cycle budget turns a silent slave into a SLVERR + timeout.
module axi_lite_master #(
    parameter int A_DATA_WIDTH   = 32,
    parameter int WD_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [A_DATA_WIDTH-1:0]  cmd_addr,
    input  logic [WD_DATA_WIDTH-1:0] cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WD_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     rsp_timeout,
    output logic [A_DATA_WIDTH-1:0]  waddr_packet,
    output logic                     waddr_valid,
    input  logic                     waddr_ready,
    output logic [WD_DATA_WIDTH-1:0] wdata_packet,
    output logic                     wdata_valid,
    input  logic                     wdata_ready,
    input  logic [1:0]               wresp_packet,
    input  logic                     wresp_valid,
    output logic                     wresp_ready,
    output logic [A_DATA_WIDTH-1:0]  raddr_packet,
    output logic                     raddr_valid,
    input  logic                     raddr_ready,
    input  logic [WD_DATA_WIDTH-1:0] rdata_packet,
    input  logic                     rdata_valid,
    output logic                     rdata_ready,
    input  logic [1:0]               rresp_packet
);
    localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   T_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          busy, expired, step, aw_fin, w_fin;

    // A write channel is finished once its valid has dropped or it handshakes this cycle;
    // the registered valid doubles as the per-channel "not yet done" flag.
    assign aw_fin  = !waddr_valid || waddr_ready;
    assign w_fin   = !wdata_valid || wdata_ready;
    assign busy    = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    assign expired = (cnt >= T_LAST);

    // step = the current state makes forward progress at this edge
    always_comb begin
        step = 1'b0;
        case (state)
            WR_REQ:  step = aw_fin && w_fin;
            WR_RESP: step = wresp_valid;
            RD_REQ:  step = raddr_ready;
            RD_DATA: step = rdata_valid;
            default: step = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b00;
            rsp_timeout  <= 1'b0;
            waddr_packet <= '0;
            waddr_valid  <= 1'b0;
            wdata_packet <= '0;
            wdata_valid  <= 1'b0;
            wresp_ready  <= 1'b0;
            raddr_packet <= '0;
            raddr_valid  <= 1'b0;
            rdata_ready  <= 1'b0;
        end else if (busy && expired && !step) begin
            waddr_valid <= 1'b0;
            wdata_valid <= 1'b0;
            wresp_ready <= 1'b0;
            raddr_valid <= 1'b0;
            rdata_ready <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_resp    <= 2'b10;
            rsp_rdata   <= '0;
            rsp_valid   <= 1'b1;
            state       <= DONE;
        end else begin
            if (busy)
                cnt <= cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        cnt         <= '0;
                        rsp_timeout <= 1'b0;
                        if (cmd_write) begin
                            waddr_packet <= cmd_addr;
                            wdata_packet <= cmd_wdata;
                            waddr_valid  <= 1'b1;
                            wdata_valid  <= 1'b1;
                            state        <= WR_REQ;
                        end else begin
                            raddr_packet <= cmd_addr;
                            raddr_valid  <= 1'b1;
                            state        <= RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (waddr_ready) waddr_valid <= 1'b0;
                    if (wdata_ready) wdata_valid <= 1'b0;
                    if (aw_fin && w_fin) begin
                        wresp_ready <= 1'b1;
                        state       <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (wresp_valid) begin
                        wresp_ready <= 1'b0;
                        rsp_resp    <= wresp_packet;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                RD_REQ: begin
                    if (raddr_ready) begin
                        raddr_valid <= 1'b0;
                        rdata_ready <= 1'b1;
                        state       <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rdata_valid) begin
                        rdata_ready <= 1'b0;
                        rsp_rdata   <= rdata_packet;
                        rsp_resp    <= rresp_packet;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed + randomized-ready bench for axi_lite_master against a small AXI-lite slave model
// that drives its channels on the falling edge.
module tb_axi_lite_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] waddr_packet, wdata_packet, raddr_packet;
    logic        waddr_valid, wdata_valid, raddr_valid, wresp_ready, rdata_ready;
    logic        waddr_ready = 1'b0, wdata_ready = 1'b0, raddr_ready = 1'b0;
    logic        wresp_valid = 1'b0, rdata_valid = 1'b0;
    logic [1:0]  wresp_packet = 2'b00, rresp_packet = 2'b00;
    logic [31:0] rdata_packet = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    axi_lite_master #(.A_DATA_WIDTH(32), .WD_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .waddr_packet(waddr_packet), .waddr_valid(waddr_valid), .waddr_ready(waddr_ready),
        .wdata_packet(wdata_packet), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wresp_packet(wresp_packet), .wresp_valid(wresp_valid), .wresp_ready(wresp_ready),
        .raddr_packet(raddr_packet), .raddr_valid(raddr_valid), .raddr_ready(raddr_ready),
        .rdata_packet(rdata_packet), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .rresp_packet(rresp_packet)
    );

    always #5 clk = ~clk;

    // slave configuration (written by the stimulus only)
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    bit          rnd_mode, b_en, r_ovr_en;
    logic [31:0] r_ovr;

    // slave state (written by the slave process only)
    bit          aw_pend, aw_got, w_pend, w_got, both_done, b_sent, ar_pend, ar_got, r_sent;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          aw_beats, w_beats, b_beats, ar_beats, r_beats, aw_vcyc, w_vcyc;
    int          aw_bad, w_bad, ar_bad;
    logic [31:0] s_addr, s_data, aw_addr, w_data, ar_addr;
    logic [31:0] s_mem   [64] = '{default: 32'h0};
    logic [31:0] exp_mem [64] = '{default: 32'h0};

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        case (a[7:6])
            2'b11:   return 2'b10;
            2'b10:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // AXI-lite slave model: decides readies/valids for the coming rising edge
    always @(negedge clk) begin
        if (!rst) begin
            waddr_ready = 0; wdata_ready = 0; wresp_valid = 0; raddr_ready = 0; rdata_valid = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                s_addr = cmd_addr; s_data = cmd_wdata;
                aw_pend = 0; aw_got = 0; w_pend = 0; w_got = 0; both_done = 0; b_sent = 0;
                ar_pend = 0; ar_got = 0; r_sent = 0;
                aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
                aw_vcyc = 0; w_vcyc = 0; aw_bad = 0; w_bad = 0; ar_bad = 0;
            end
            if (both_done && !b_sent && b_en) begin
                if (b_cnt != 0) begin wresp_valid = 0; b_cnt--; end
                else begin
                    wresp_valid = 1; wresp_packet = resp_of(aw_addr);
                    if (wresp_ready) begin b_sent = 1; b_beats++; s_mem[aw_addr[7:2]] = w_data; end
                end
            end else wresp_valid = 0;
            if (ar_got && !r_sent) begin
                if (r_cnt != 0) begin rdata_valid = 0; r_cnt--; end
                else begin
                    rdata_valid  = 1;
                    rdata_packet = r_ovr_en ? r_ovr : s_mem[ar_addr[7:2]];
                    rresp_packet = resp_of(ar_addr);
                    if (rdata_ready) begin r_sent = 1; r_beats++; end
                end
            end else rdata_valid = 0;
            // AW
            if (waddr_valid) aw_vcyc++;
            if (waddr_valid && !aw_got) begin
                if (waddr_packet !== s_addr) aw_bad++;
                if (!aw_pend) begin aw_pend = 1; aw_cnt = rnd_mode ? int'($urandom_range(0, 3)) : aw_delay; end
                if (aw_cnt == 0) begin waddr_ready = 1; aw_got = 1; aw_addr = waddr_packet; end
                else begin waddr_ready = 0; aw_cnt--; end
            end else waddr_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (waddr_valid && waddr_ready) aw_beats++;
            // W
            if (wdata_valid) w_vcyc++;
            if (wdata_valid && !w_got) begin
                if (wdata_packet !== s_data) w_bad++;
                if (!w_pend) begin w_pend = 1; w_cnt = rnd_mode ? int'($urandom_range(0, 3)) : w_delay; end
                if (w_cnt == 0) begin wdata_ready = 1; w_got = 1; w_data = wdata_packet; end
                else begin wdata_ready = 0; w_cnt--; end
            end else wdata_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wdata_valid && wdata_ready) w_beats++;
            if (aw_got && w_got && !both_done) begin
                both_done = 1; b_cnt = rnd_mode ? int'($urandom_range(0, 3)) : b_delay;
            end
            // AR
            if (raddr_valid && !ar_got) begin
                if (raddr_packet !== s_addr) ar_bad++;
                if (!ar_pend) begin ar_pend = 1; ar_cnt = rnd_mode ? int'($urandom_range(0, 3)) : ar_delay; end
                if (ar_cnt == 0) begin
                    raddr_ready = 1; ar_got = 1; ar_addr = raddr_packet;
                    r_cnt = rnd_mode ? int'($urandom_range(0, 3)) : r_delay;
                end else begin raddr_ready = 0; ar_cnt--; end
            end else raddr_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (raddr_valid && raddr_ready) ar_beats++;
        end
    end

    // Issue one command and wait for rsp_valid; rcyc is the cycle rsp_valid is first seen
    // (cycle 0 = command handshake edge), reqcyc the first cycle any request valid is seen.
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic [1:0] rs, output logic to,
                          output int rcyc, output int reqcyc);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1;
        cmd_valid = 0;
        rcyc = 1; reqcyc = 0;
        while (!rsp_valid && rcyc < 100) begin
            if (reqcyc == 0 && (waddr_valid || wdata_valid || raddr_valid)) reqcyc = rcyc;
            @(posedge clk); #1; rcyc++;
        end
        chk("rsp_seen", rsp_valid, 1);
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        if (wr && rsp_valid && !rsp_timeout) exp_mem[a[7:2]] = d;
    endtask

    task automatic ack();
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("ack_rsp_valid_drop", rsp_valid, 0);
        chk("ack_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, snap_d;
        logic [1:0]  rs, snap_r;
        logic        to, snap_t, seen;
        int          rcyc, reqcyc, guard;

        rst = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        rnd_mode = 0; b_en = 1; r_ovr_en = 0; r_ovr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {cmd_ready, rsp_valid, rsp_resp, rsp_timeout, waddr_valid, wdata_valid,
                          wresp_ready, raddr_valid, rdata_ready}, 0);
        chk("reset_pkts", {waddr_packet, wdata_packet}, 0);
        chk("reset_rdata", {raddr_packet, rsp_rdata}, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        // minimum write
        do_txn(1, 32'h0000_0040, 32'hDEAD_BEEF, rd, rs, to, rcyc, reqcyc);
        chk("t1_req_cycle", reqcyc, 1);
        chk("t1_rsp_cycle", rcyc, 3);
        chk("t1_resp", rs, 0);
        chk("t1_timeout", to, 0);
        chk("t1_rdata", rd, 0);
        chk("t1_aw_addr", aw_addr, 32'h0000_0040);
        chk("t1_w_data", w_data, 32'hDEAD_BEEF);
        chk("t1_beats", {8'(aw_beats), 8'(w_beats), 8'(b_beats)}, 24'h010101);
        ack();

        // AW ready delayed 7 cycles, W immediate
        aw_delay = 7;
        do_txn(1, 32'h0000_0050, 32'h0123_4567, rd, rs, to, rcyc, reqcyc);
        chk("t2_aw_valid_cycles", aw_vcyc, 8);
        chk("t2_w_valid_cycles", w_vcyc, 1);
        chk("t2_aw_pkt_unstable", aw_bad, 0);
        chk("t2_beats", {8'(aw_beats), 8'(w_beats)}, 16'h0101);
        chk("t2_rsp_cycle", rcyc, 10);
        chk("t2_resp", rs, 0);
        ack();
        aw_delay = 0;

        // reads with override data
        r_ovr_en = 1; r_ovr = 32'h1234_5678; r_delay = 5;
        do_txn(0, 32'h0000_0004, 32'h0, rd, rs, to, rcyc, reqcyc);
        chk("t3_req_cycle", reqcyc, 1);
        chk("t3_rsp_cycle", rcyc, 8);
        chk("t3_rdata", rd, 32'h1234_5678);
        chk("t3_resp", rs, 0);
        chk("t3_timeout", to, 0);
        ack();
        r_delay = 0; r_ovr = 32'hFFFF_FFFE;
        do_txn(0, 32'h1000_0000, 32'h0, rd, rs, to, rcyc, reqcyc);
        chk("t3b_rsp_cycle", rcyc, 3);
        chk("t3b_rdata", rd, 32'hFFFF_FFFE);
        chk("t3b_ar_addr", ar_addr, 32'h1000_0000);
        ack();

        // no B response -> timeout
        b_en = 0;
        do_txn(1, 32'h0000_0080, 32'h5555_AAAA, rd, rs, to, rcyc, reqcyc);
        chk("t4_rsp_cycle", rcyc, 17);
        chk("t4_timeout", to, 1);
        chk("t4_resp", rs, 2'b10);
        chk("t4_rdata", rd, 0);
        b_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_late_b_ready", wresp_ready, 0);
        chk("t4_late_b_beats", b_beats, 0);
        ack();
        r_ovr = 32'hA5A5_0001;
        do_txn(0, 32'h0000_0004, 32'h0, rd, rs, to, rcyc, reqcyc);
        chk("t4b_rdata", rd, 32'hA5A5_0001);
        chk("t4b_resp_to", {rs, to}, 3'b000);
        ack();
        r_ovr_en = 0;

        // hold rsp_ready low for 10 cycles in DONE
        do_txn(1, 32'h0000_0044, 32'h0BAD_F00D, rd, rs, to, rcyc, reqcyc);
        snap_d = rsp_rdata; snap_r = rsp_resp; snap_t = rsp_timeout;
        chk("t5_resp", snap_r, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_outputs", {rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout},
                {1'b1, 1'b0, snap_d, snap_r, snap_t});
        end
        ack();

        // reset while waiting in WR_RESP
        b_delay = 10;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0048; cmd_wdata = 32'h7777_1111;
        @(posedge clk); #1;
        cmd_valid = 0;
        guard = 0;
        while (!wresp_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        chk("t6_in_wr_resp", wresp_ready, 1);
        #2;
        rst = 0;
        #1;
        chk("t6_async_ctl", {cmd_ready, rsp_valid, rsp_resp, rsp_timeout, waddr_valid, wdata_valid,
                             wresp_ready, raddr_valid, rdata_ready}, 0);
        chk("t6_async_pkts", {waddr_packet, wdata_packet}, 0);
        chk("t6_async_rdata", {raddr_packet, rsp_rdata}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        chk("t6_no_rsp_after_reset", seen, 0);
        chk("t6_idle_after_reset", {cmd_ready, wresp_ready}, 2'b10);
        b_delay = 0;

        // mixed commands with random readies and scoreboarded memory
        rnd_mode = 1;
        for (int n = 0; n < 200; n++) begin
            bit          wr;
            logic [31:0] a, d, exp_rd;
            wr = 1'($urandom_range(0, 1));
            a  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            d  = $urandom;
            exp_rd = wr ? 32'h0 : exp_mem[a[7:2]];
            do_txn(wr, a, d, rd, rs, to, rcyc, reqcyc);
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_resp", rs, resp_of(a));
            chk("rnd_timeout", to, 0);
            if (wr) begin
                chk("rnd_wr_beats", {8'(aw_beats), 8'(w_beats), 8'(b_beats)}, 24'h010101);
                chk("rnd_wr_pkts", {aw_bad[15:0], w_bad[15:0]}, 0);
            end else begin
                chk("rnd_rd_beats", {8'(ar_beats), 8'(r_beats)}, 16'h0101);
                chk("rnd_rd_pkt", ar_bad, 0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            ack();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
